layer_frame_sched: RTL and testbench
====================================

LAYER_FRAME_SCHED -- requirements
Module: layer_frame_sched

Interface
REQ-001 SHALL have parameter NumberOfK, default 8: kernel channels held in inter-layer memory per frame.
REQ-002 SHALL have parameter ImageWidth, default 8: layer-2 input width; one channel = ImageWidth*ImageWidth pixels.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port res_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream pixel valid into layer 1.
REQ-006 SHALL have port l1_image_done  input  1  one-cycle pulse: inter-layer memory holds a complete frame.
REQ-007 SHALL have port l2_pooling_done  input  1  one-cycle pulse: layer 2 finished current channel.
REQ-008 SHALL have port rd_stall  input  1  layer 2 cannot accept a pixel this cycle.
REQ-009 SHALL have port up_ready  output  1  upstream may send pixels.
REQ-010 SHALL have port rd_en  output  1  memory read strobe.
REQ-011 SHALL have port rd_channel  output  $clog2(NumberOfK)  channel being read.
REQ-012 SHALL have port rd_addr  output  $clog2(ImageWidth*ImageWidth)  pixel index within channel.
REQ-013 SHALL have port l2_res_n  output  1  active-low soft reset to layer 2.
REQ-014 SHALL have port set_done  output  1  one-cycle pulse: all channels of frame processed.
REQ-015 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-016 SHALL implement states IDLE, FILL, RELEASE, DRAIN, WAIT, FLUSH, DONE; all outputs registered.
REQ-017 IDLE: up_ready=1, l2_res_n=0, rd_en=0; in_valid=1 -> FILL.
REQ-018 FILL: up_ready=1, l2_res_n=0; l1_image_done -> RELEASE with rd_channel=0, rd_addr=0.
REQ-019 RELEASE (1 cycle): up_ready=0, l2_res_n=1 -> DRAIN.
REQ-020 DRAIN: rd_en=!rd_stall; rd_addr increments by 1 after each cycle with rd_en=1; rd_en for addr ImageWidth*ImageWidth-1 -> WAIT next cycle.
REQ-021 rd_stall=1 SHALL hold rd_addr, rd_channel and deassert rd_en in the following cycle (1-cycle stall latency).
REQ-022 WAIT: rd_en=0, l2_res_n=1; l2_pooling_done -> DONE if rd_channel==NumberOfK-1, else FLUSH.
REQ-023 FLUSH (1 cycle): l2_res_n=0, rd_channel+1, rd_addr=0 -> RELEASE.
REQ-024 DONE (1 cycle): set_done=1, l2_res_n=0 -> IDLE.
REQ-025 up_ready SHALL be 0 in RELEASE, DRAIN, WAIT, FLUSH, DONE (single-buffered memory).
REQ-026 l1_image_done outside FILL SHALL be ignored and set err.
REQ-027 l2_pooling_done outside WAIT SHALL be ignored and set err.
REQ-028 l1_image_done coincident with in_valid in IDLE SHALL enter FILL only (pulse counted as error per REQ-026).
REQ-029 rd_addr and rd_channel SHALL never exceed their maxima; no wrap occurs inside DRAIN.
REQ-030 Per frame exactly NumberOfK*ImageWidth*ImageWidth rd_en cycles SHALL occur.

Reset
REQ-031 res_n=0 SHALL asynchronously force IDLE, up_ready=1, l2_res_n=0, rd_en=0, rd_channel=0, rd_addr=0, set_done=0, err=0.
REQ-032 Reset mid-frame SHALL abandon the frame; no set_done; first post-reset in_valid starts FILL.
REQ-033 err SHALL clear only on res_n.

Structure
REQ-034 State enum and derived widths (channel, pixel-count) SHALL live in the shared CNN package.
REQ-035 Block SHALL be one module; optional sub-module sched_counter (parameterised saturating up-counter with clear) for rd_addr/rd_channel.

Verification
REQ-036 Defaults, in_valid then l1_image_done, no stall, pooling_done 5 cycles after each WAIT entry -> 8 channels x 64 rd_en, set_done once, err=0.
REQ-037 rd_stall high 3 cycles mid-DRAIN at addr 20 -> rd_addr holds 20-21 boundary, 64 reads still issued, no duplicate address.
REQ-038 l2_pooling_done during DRAIN -> err=1, state unaffected, frame completes normally.
REQ-039 res_n low during channel 3 -> outputs at reset values immediately, no set_done; new frame completes fully.
REQ-040 Check l2_res_n: low exactly 1 cycle between channels (FLUSH), high from RELEASE through WAIT, low in IDLE/FILL/DONE.
REQ-041 l1_image_done in IDLE -> err=1, stays IDLE, up_ready=1.

Source files
------------

// File: rtl/layer_frame_sched_pkg.sv
// Shared types for the inter-layer frame scheduler: FSM state encoding and
// counter-width helpers derived from the channel/pixel geometry.
package layer_frame_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RELEASE,
    ST_DRAIN,
    ST_WAIT,
    ST_FLUSH,
    ST_DONE
  } sched_state_e;

  localparam int unsigned DefNumberOfK   = 8;
  localparam int unsigned DefImageWidth  = 8;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_frame_sched_counter.sv
// Saturating up-counter with synchronous clear; stops at MaxVal and never wraps.
module layer_frame_sched_counter #(
  parameter int unsigned Width  = 3,
  parameter int unsigned MaxVal = 7
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] count
);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != Width'(MaxVal))) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/layer_frame_sched.sv
// Sequences one frame of the single-buffered inter-layer memory: layer 1 fills
// it, then each channel is streamed to layer 2 with a soft reset between channels.
module layer_frame_sched
  import layer_frame_sched_pkg::*;
#(
  parameter int unsigned NumberOfK  = DefNumberOfK,
  parameter int unsigned ImageWidth = DefImageWidth
) (
  input  logic                                          clk,
  input  logic                                          res_n,
  input  logic                                          in_valid,
  input  logic                                          l1_image_done,
  input  logic                                          l2_pooling_done,
  input  logic                                          rd_stall,
  output logic                                          up_ready,
  output logic                                          rd_en,
  output logic [cnt_width(NumberOfK)-1:0]               rd_channel,
  output logic [cnt_width(ImageWidth*ImageWidth)-1:0]   rd_addr,
  output logic                                          l2_res_n,
  output logic                                          set_done,
  output logic                                          err
);

  localparam int unsigned Pix  = ImageWidth * ImageWidth;
  localparam int unsigned ChW  = cnt_width(NumberOfK);
  localparam int unsigned PixW = cnt_width(Pix);

  sched_state_e state_q, state_d;
  logic up_ready_d, rd_en_d, l2_res_n_d, set_done_d, err_d;
  logic addr_clr, addr_inc, ch_clr, ch_inc;
  logic addr_last, ch_last;

  assign addr_last = (rd_addr == PixW'(Pix - 1));
  assign ch_last   = (rd_channel == ChW'(NumberOfK - 1));

  layer_frame_sched_counter #(.Width(PixW), .MaxVal(Pix - 1)) u_addr_cnt (
    .clk   (clk),
    .res_n (res_n),
    .clr   (addr_clr),
    .inc   (addr_inc),
    .count (rd_addr)
  );

  layer_frame_sched_counter #(.Width(ChW), .MaxVal(NumberOfK - 1)) u_ch_cnt (
    .clk   (clk),
    .res_n (res_n),
    .clr   (ch_clr),
    .inc   (ch_inc),
    .count (rd_channel)
  );

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q  <= ST_IDLE;
      up_ready <= 1'b1;
      rd_en    <= 1'b0;
      l2_res_n <= 1'b0;
      set_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      up_ready <= up_ready_d;
      rd_en    <= rd_en_d;
      l2_res_n <= l2_res_n_d;
      set_done <= set_done_d;
      err      <= err_d;
    end
  end

  // Next state; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_d  = state_q;
    addr_clr = 1'b0;
    addr_inc = 1'b0;
    ch_clr   = 1'b0;
    ch_inc   = 1'b0;
    err_d    = err | (l1_image_done && (state_q != ST_FILL))
                   | (l2_pooling_done && (state_q != ST_WAIT));

    unique case (state_q)
      ST_IDLE:    if (in_valid) state_d = ST_FILL;
      ST_FILL: begin
        if (l1_image_done) begin
          state_d  = ST_RELEASE;
          addr_clr = 1'b1;
          ch_clr   = 1'b1;
        end
      end
      ST_RELEASE: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (rd_en) begin
          if (addr_last) state_d  = ST_WAIT;
          else           addr_inc = 1'b1;
        end
      end
      ST_WAIT: begin
        if (l2_pooling_done) begin
          if (ch_last) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_FLUSH;
            ch_inc   = 1'b1;
            addr_clr = 1'b1;
          end
        end
      end
      ST_FLUSH:   state_d = ST_RELEASE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    up_ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
    l2_res_n_d = (state_d == ST_RELEASE) || (state_d == ST_DRAIN) || (state_d == ST_WAIT);
    set_done_d = (state_d == ST_DONE);
    // Stall is seen one cycle late: it suppresses the strobe of the following cycle.
    rd_en_d    = (state_d == ST_DRAIN) && !rd_stall;
  end

endmodule

// File: tb/tb_layer_frame_sched.sv
// Scoreboard bench for layer_frame_sched: expected read/done events are queued
// by the stimulus and consumed by a monitor as the DUT presents them.
module tb_layer_frame_sched;

  localparam int K   = 8;
  localparam int IW  = 8;
  localparam int PIX = IW * IW;

  logic clk = 1'b0;
  logic res_n, in_valid, l1_image_done, rd_stall;
  logic pool_resp, pool_inj, l2_pooling_done;
  logic up_ready, rd_en, l2_res_n, set_done, err;
  logic [2:0] rd_channel;
  logic [5:0] rd_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit is_done;
    int ch;
    int addr;
  } ev_t;
  ev_t sb[$];

  assign l2_pooling_done = pool_resp | pool_inj;

  always #5 clk = ~clk;

  layer_frame_sched #(.NumberOfK(K), .ImageWidth(IW)) dut (
    .clk             (clk),
    .res_n           (res_n),
    .in_valid        (in_valid),
    .l1_image_done   (l1_image_done),
    .l2_pooling_done (l2_pooling_done),
    .rd_stall        (rd_stall),
    .up_ready        (up_ready),
    .rd_en           (rd_en),
    .rd_channel      (rd_channel),
    .rd_addr         (rd_addr),
    .l2_res_n        (l2_res_n),
    .set_done        (set_done),
    .err             (err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    for (int c = 0; c < K; c++)
      for (int a = 0; a < PIX; a++) sb.push_back('{is_done: 1'b0, ch: c, addr: a});
    sb.push_back('{is_done: 1'b1, ch: 0, addr: 0});
  endtask

  // Monitor: every strobe or done pulse must match the next queued event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (res_n && (rd_en || set_done)) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          if (rd_en) begin
            chk("read_kind", int'(rd_en), int'(!e.is_done));
            chk("read_ch", int'(rd_channel), e.ch);
            chk("read_addr", int'(rd_addr), e.addr);
            chk("read_l2res", int'(l2_res_n), 1);
          end else begin
            chk("done_kind", int'(set_done), int'(e.is_done));
          end
        end
      end
    end
  end

  // Layer-2 model: answers each channel 5 cycles into WAIT and checks the soft-reset window.
  initial begin
    int ch;
    pool_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (res_n && rd_en && int'(rd_addr) == PIX - 1) begin
        ch = int'(rd_channel);
        @(negedge clk);
        chk("wait_l2res_high", int'(l2_res_n), 1);
        chk("wait_up_ready", int'(up_ready), 0);
        repeat (4) @(posedge clk);
        #1 pool_resp = 1'b1;
        @(posedge clk);
        #1 pool_resp = 1'b0;
        @(negedge clk);
        chk("flush_done_l2res_low", int'(l2_res_n), 0);
        chk("flush_done_up_ready", int'(up_ready), 0);
        @(negedge clk);
        if (ch != K - 1) begin
          chk("release_l2res_high", int'(l2_res_n), 1);
        end else begin
          chk("idle_up_ready", int'(up_ready), 1);
          chk("idle_l2res_low", int'(l2_res_n), 0);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    cyc(); in_valid = 1'b1;
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    chk("fill_up_ready", int'(up_ready), 1);
    repeat (3) cyc();
    push_frame();
    l1_image_done = 1'b1;
    cyc(); l1_image_done = 1'b0;
  endtask

  task automatic wait_read(input int ch, input int addr);
    bit hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      hit = rd_en && int'(rd_channel) == ch && int'(rd_addr) == addr;
    end
    if (!hit) chk("wait_read_timeout", 0, 1);
  endtask

  task automatic wait_drained();
    int i;
    for (i = 0; i < 5000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) chk("frame_timeout", sb.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_up_ready"}, int'(up_ready), 1);
    chk({tag, "_l2_res_n"}, int'(l2_res_n), 0);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_rd_channel"}, int'(rd_channel), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_set_done"}, int'(set_done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    res_n = 1'b0; in_valid = 1'b0; l1_image_done = 1'b0; rd_stall = 1'b0; pool_inj = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    cyc(); res_n = 1'b1;

    // Clean frame.
    start_frame();
    wait_drained();
    chk("frame1_err", int'(err), 0);

    // Three-cycle stall right after address 20 of channel 0.
    start_frame();
    wait_read(0, 20);
    rd_stall = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_rd_en", int'(rd_en), 0);
    chk("stall_addr_hold", int'(rd_addr), 21);
    @(posedge clk);
    @(posedge clk);
    #1 rd_stall = 1'b0;
    wait_drained();
    chk("frame2_err", int'(err), 0);

    // Stray pooling_done while draining channel 2.
    start_frame();
    wait_read(2, 30);
    cyc(); pool_inj = 1'b1;
    cyc(); pool_inj = 1'b0;
    @(negedge clk);
    chk("stray_pool_err", int'(err), 1);
    chk("stray_pool_still_drain", int'(rd_en), 1);
    wait_drained();
    chk("frame3_err_sticky", int'(err), 1);

    // Reset in the middle of channel 3.
    start_frame();
    wait_read(3, 10);
    res_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    sb.delete();
    repeat (2) cyc();
    res_n = 1'b1;

    // in_valid and l1_image_done together in IDLE: only FILL, flagged as error.
    cyc(); in_valid = 1'b1; l1_image_done = 1'b1;
    cyc(); in_valid = 1'b0; l1_image_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("coinc_err", int'(err), 1);
    chk("coinc_fill_up_ready", int'(up_ready), 1);
    chk("coinc_no_release", int'(l2_res_n), 0);
    push_frame();
    cyc(); l1_image_done = 1'b1;
    cyc(); l1_image_done = 1'b0;
    wait_drained();

    // l1_image_done alone in IDLE.
    res_n = 1'b0;
    cyc(); res_n = 1'b1;
    cyc(); l1_image_done = 1'b1;
    cyc(); l1_image_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_l1_err", int'(err), 1);
    chk("idle_l1_up_ready", int'(up_ready), 1);
    chk("idle_l1_l2res", int'(l2_res_n), 0);
    chk("idle_l1_rd_en", int'(rd_en), 0);
    chk("idle_l1_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
